// File: rtl/spi_xform_slave_pkg.sv
// Shared types and the word transform for the SPI transform slave.
package spi_xform_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] FUNC_BITREV = 2'd0;
    localparam logic [1:0] FUNC_ECHO   = 2'd1;
    localparam logic [1:0] FUNC_INVERT = 2'd2;

    // Word is right-aligned in MAX_W bits; caller truncates to its own width.
    function automatic logic [MAX_W-1:0] xform(input logic [MAX_W-1:0] word,
                                               input logic [1:0]       func,
                                               input int unsigned      width);
        logic [MAX_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < MAX_W; i++) begin
            rev[i] = word[MAX_W-1-i];
        end
        case (func)
            FUNC_BITREV: xform = rev >> (MAX_W - width);
            FUNC_ECHO:   xform = word;
            FUNC_INVERT: xform = ~word;
            default:     xform = word;
        endcase
    endfunction

endpackage

// File: rtl/spi_xform_slave_if.sv
// SPI pins plus frame status seen by the testbench.
interface spi_xform_slave_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sck;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              frame_done;
    logic              abort;

    modport slave  (input  sck, ss, mosi, output miso, rx_data, frame_done, abort);
    modport master (output sck, ss, mosi, input  miso, rx_data, frame_done, abort);
endinterface

// File: rtl/spi_xform_slave_pin_sync.sv
// Synchronises sck/ss/mosi into the clock domain and flags sck edges
// relative to the idle level CPOL.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        CPOL        = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_s,
    output logic ss_s,
    output logic mosi_s,
    output logic lead_evt,
    output logic trail_evt
);

    logic [SYNC_STAGES-1:0] sck_ff;
    logic [SYNC_STAGES-1:0] ss_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sck_d;

    // Flops reset to the pin idle levels so reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_ff  <= {SYNC_STAGES{CPOL}};
            ss_ff   <= '1;
            mosi_ff <= '0;
            sck_d   <= CPOL;
        end else begin
            sck_ff  <= {sck_ff[SYNC_STAGES-2:0], sck};
            ss_ff   <= {ss_ff[SYNC_STAGES-2:0], ss};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            sck_d   <= sck_ff[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_ff[SYNC_STAGES-1];
    assign ss_s      = ss_ff[SYNC_STAGES-1];
    assign mosi_s    = mosi_ff[SYNC_STAGES-1];
    assign lead_evt  = (sck_s != sck_d) && (sck_d == CPOL);
    assign trail_evt = (sck_s != sck_d) && (sck_s == CPOL);

endmodule

// File: rtl/spi_xform_slave.sv
// SPI slave: receives a DATA_W word, returns its transform on miso.
// Optional SPI_XFORM_PARITY_EN appends an even-parity bit to the TX phase.
module spi_xform_slave
    import spi_xform_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SPI_MODE    = 0,
    parameter int unsigned FUNC        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    spi_xform_slave_if.slave bus
);

    localparam logic CPOL = 1'(SPI_MODE >> 1);
    localparam logic CPHA = 1'(SPI_MODE);
`ifdef SPI_XFORM_PARITY_EN
    localparam int unsigned TX_BITS = DATA_W + 1;
`else
    localparam int unsigned TX_BITS = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(TX_BITS + 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rx_shift, rx_shift_n;
    logic [TX_BITS-1:0]  tx_shift, tx_shift_n;
    logic [DATA_W-1:0]   rx_data_q, rx_data_n;
    logic                miso_q, miso_n;
    logic                frame_done_q, frame_done_n;
    logic                abort_q, abort_n;

    logic sck_s, ss_s, mosi_s, lead_evt, trail_evt;
    logic sample_evt, shift_evt;
    logic unused_sck;
    logic [DATA_W-1:0]  word_c;
    logic [DATA_W-1:0]  xw_c;
    logic [TX_BITS-1:0] tx_load_c;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .sck       (bus.sck),
        .ss        (bus.ss),
        .mosi      (bus.mosi),
        .sck_s     (sck_s),
        .ss_s      (ss_s),
        .mosi_s    (mosi_s),
        .lead_evt  (lead_evt),
        .trail_evt (trail_evt)
    );

    assign unused_sck = sck_s;
    assign sample_evt = CPHA ? trail_evt : lead_evt;
    assign shift_evt  = CPHA ? lead_evt  : trail_evt;

    assign word_c = {rx_shift[DATA_W-2:0], mosi_s};
    assign xw_c   = DATA_W'(xform(MAX_W'(word_c), 2'(FUNC), DATA_W));
`ifdef SPI_XFORM_PARITY_EN
    assign tx_load_c = {xw_c, ^xw_c};
`else
    assign tx_load_c = xw_c;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_data_q    <= '0;
            miso_q       <= 1'b1;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rx_shift     <= rx_shift_n;
            tx_shift     <= tx_shift_n;
            rx_data_q    <= rx_data_n;
            miso_q       <= miso_n;
            frame_done_q <= frame_done_n;
            abort_q      <= abort_n;
        end
    end

    // ss high wins over any sck event in the same cycle.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rx_shift_n   = rx_shift;
        tx_shift_n   = tx_shift;
        rx_data_n    = rx_data_q;
        miso_n       = miso_q;
        frame_done_n = 1'b0;
        abort_n      = 1'b0;

        if (state != IDLE && ss_s) begin
            state_n = IDLE;
            miso_n  = 1'b1;
            cnt_n   = '0;
            abort_n = (state == RX) || (state == TX);
        end else begin
            case (state)
                IDLE: begin
                    miso_n = 1'b1;
                    if (!ss_s) begin
                        state_n    = RX;
                        cnt_n      = '0;
                        rx_shift_n = '0;
                    end
                end
                RX: begin
                    if (sample_evt) begin
                        rx_shift_n = word_c;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            rx_data_n  = word_c;
                            tx_shift_n = tx_load_c;
                            cnt_n      = '0;
                            state_n    = TX;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                TX: begin
                    if (shift_evt) begin
                        miso_n     = tx_shift[TX_BITS-1];
                        tx_shift_n = {tx_shift[TX_BITS-2:0], 1'b0};
                    end
                    if (sample_evt) begin
                        if (cnt == CNT_W'(TX_BITS - 1)) begin
                            frame_done_n = 1'b1;
                            cnt_n        = '0;
                            state_n      = DONE;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (shift_evt) begin
                        miso_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.miso       = miso_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.abort      = abort_q;

endmodule

// File: tb/tb_spi_xform_slave.sv
// Scoreboard bench: four slaves in different modes/transforms driven by a
// behavioural SPI master; returned miso words checked against a local model.
module tb_spi_xform_slave;
    import spi_xform_pkg::*;

    localparam int HALF = 6;
`ifdef SPI_XFORM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] sck_v  = 4'b1010;
    logic [3:0] ss_v   = 4'b1111;
    logic [3:0] mosi_v = 4'b0000;
    wire  [3:0] miso_v;

    int mode_of  [4] = '{0, 3, 1, 2};
    int width_of [4] = '{8, 16, 8, 8};
    int func_of  [4] = '{0, 0, 1, 2};

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    int abort_cnt[4] = '{0, 0, 0, 0};
    logic [31:0] exp_q[$];

    spi_xform_slave_if #(.DATA_W(8))  b0 ();
    spi_xform_slave_if #(.DATA_W(16)) b1 ();
    spi_xform_slave_if #(.DATA_W(8))  b2 ();
    spi_xform_slave_if #(.DATA_W(8))  b3 ();

    assign b0.sck = sck_v[0]; assign b0.ss = ss_v[0]; assign b0.mosi = mosi_v[0];
    assign b1.sck = sck_v[1]; assign b1.ss = ss_v[1]; assign b1.mosi = mosi_v[1];
    assign b2.sck = sck_v[2]; assign b2.ss = ss_v[2]; assign b2.mosi = mosi_v[2];
    assign b3.sck = sck_v[3]; assign b3.ss = ss_v[3]; assign b3.mosi = mosi_v[3];
    assign miso_v = {b3.miso, b2.miso, b1.miso, b0.miso};

    spi_xform_slave #(.DATA_W(8),  .SPI_MODE(0), .FUNC(0), .SYNC_STAGES(2))
        dut0 (.clock(clk), .reset(rst), .bus(b0));
    spi_xform_slave #(.DATA_W(16), .SPI_MODE(3), .FUNC(0), .SYNC_STAGES(2))
        dut1 (.clock(clk), .reset(rst), .bus(b1));
    spi_xform_slave #(.DATA_W(8),  .SPI_MODE(1), .FUNC(1), .SYNC_STAGES(2))
        dut2 (.clock(clk), .reset(rst), .bus(b2));
    spi_xform_slave #(.DATA_W(8),  .SPI_MODE(2), .FUNC(2), .SYNC_STAGES(2))
        dut3 (.clock(clk), .reset(rst), .bus(b3));

    always @(negedge clk) begin
        if (b0.frame_done) done_cnt[0]++;
        if (b1.frame_done) done_cnt[1]++;
        if (b2.frame_done) done_cnt[2]++;
        if (b3.frame_done) done_cnt[3]++;
        if (b0.abort) abort_cnt[0]++;
        if (b1.abort) abort_cnt[1]++;
        if (b2.abort) abort_cnt[2]++;
        if (b3.abort) abort_cnt[3]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] get_rx(input int k);
        case (k)
            0:       return 32'(b0.rx_data);
            1:       return 32'(b1.rx_data);
            2:       return 32'(b2.rx_data);
            default: return 32'(b3.rx_data);
        endcase
    endfunction

    // Expected miso bit stream, MSB first, for one full frame.
    function automatic logic [31:0] model(input int k, input logic [31:0] word);
        int w;
        logic [31:0] x;
        w = width_of[k];
        x = '0;
        case (func_of[k])
            0:       for (int i = 0; i < w; i++) x[w-1-i] = word[i];
            2:       x = ~word & mask(w);
            default: x = word & mask(w);
        endcase
`ifdef SPI_XFORM_PARITY_EN
        x = (x << 1) | 32'(^x);
`endif
        return x;
    endfunction

    // Master: runs n_cyc sck periods, collects miso at sample edges of TX bits.
    task automatic run_cycles(input int k, input logic [31:0] word, input int n_cyc,
                              output logic [31:0] got, output logic stable);
        int w;
        logic cpol, cpha, last, mbit;
        w = width_of[k];
        cpol = 1'(mode_of[k] >> 1);
        cpha = 1'(mode_of[k]);
        got = '0;
        stable = 1'b1;
        last = 1'b1;
        for (int i = 0; i < n_cyc; i++) begin
            mbit = (i < w) ? word[w-1-i] : 1'b0;
            if (!cpha) mosi_v[k] = mbit;
            repeat (HALF) @(negedge clk);
            if (cpha && i > w && miso_v[k] !== last) stable = 1'b0;
            sck_v[k] = ~cpol;
            if (!cpha && i >= w) got = {got[30:0], miso_v[k]};
            if (cpha) mosi_v[k] = mbit;
            repeat (HALF) @(negedge clk);
            sck_v[k] = cpol;
            if (cpha && i >= w) begin
                last = miso_v[k];
                got  = {got[30:0], last};
            end
        end
        repeat (HALF) @(negedge clk);
        if (cpha && n_cyc > w && miso_v[k] !== last) stable = 1'b0;
    endtask

    task automatic full_frame(input int k, input logic [31:0] word, input string tag);
        logic [31:0] got;
        logic stable;
        int d0, t;
        exp_q.push_back(model(k, word));
        d0 = done_cnt[k];
        ss_v[k] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        run_cycles(k, word, 2 * width_of[k] + PAR, got, stable);
        t = 0;
        while (done_cnt[k] == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 32'(done_cnt[k] - d0), 32'd1);
        check({tag, "_miso"}, got, exp_q.pop_front());
        check({tag, "_rx"}, get_rx(k), word & mask(width_of[k]));
        if ((mode_of[k] & 1) == 0) check({tag, "_done_idle"}, 32'(miso_v[k]), 32'd1);
        else                       check({tag, "_stable"}, 32'(stable), 32'd1);
        ss_v[k] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check({tag, "_idle"}, 32'(miso_v[k]), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic stable;
        int d0, a0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_miso%0d", k), 32'(miso_v[k]), 32'd1);
            check($sformatf("rst_rx%0d", k), get_rx(k), 32'd0);
        end
        check("rst_state", 32'(dut0.state), 32'(IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        full_frame(0, 32'h00B1, "m0_b1");
        full_frame(1, 32'h1234, "m3_1234");
        full_frame(2, 32'h005A, "m1_echo");
        full_frame(3, 32'h005A, "m2_inv");

        // Abort after three RX bits.
        a0 = abort_cnt[0];
        d0 = done_cnt[0];
        ss_v[0] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        run_cycles(0, 32'h5A, 3, got, stable);
        ss_v[0] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("abort_pulse", 32'(abort_cnt[0] - a0), 32'd1);
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("abort_miso", 32'(miso_v[0]), 32'd1);
        check("abort_rx_kept", get_rx(0), 32'h00B1);
        full_frame(0, 32'h00B1, "post_abort");
        full_frame(0, 32'h0001, "m0_01");

        // Reset mid-TX.
        a0 = abort_cnt[0];
        d0 = done_cnt[0];
        ss_v[0] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        run_cycles(0, 32'hB1, 8 + 3, got, stable);
        rst = 1'b1;
        ss_v[0] = 1'b1;
        sck_v[0] = 1'b0;
        @(negedge clk);
        check("rstx_miso", 32'(miso_v[0]), 32'd1);
        check("rstx_state", 32'(dut0.state), 32'(IDLE));
        check("rstx_rx", get_rx(0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check("rstx_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("rstx_no_abort", 32'(abort_cnt[0] - a0), 32'd0);
        full_frame(0, 32'h00B1, "post_rst");

        for (int n = 0; n < 2; n++) begin
            for (int k = 1; k < 4; k++) begin
                full_frame(k, $urandom() & mask(width_of[k]), $sformatf("rand%0d_%0d", n, k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
